// File: rtl/custom_ip_reg_bridge.sv
// APB-style register bridge: three write-strobed shadow registers feeding an IP,
// three IP snapshot registers, and a STATUS word with sticky timeout flags.
module custom_ip_reg_bridge #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned DATA_WIDTH = 96
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [4:0]            paddr_i,
  input  logic [31:0]           pwdata_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [DATA_WIDTH-1:0] reg2ip_data_o,
  output logic [2:0]            reg2ip_en_o,
  input  logic [2:0]            reg2ip_ack_i,
  input  logic [DATA_WIDTH+2:0] ip2reg_data_i,
  input  logic                  ip2reg_valid_i
);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, STALL} state_t;
  state_t state, state_next;

  logic [31:0] shadow [3];
  logic [31:0] snap   [3];
  logic [7:0]  timer  [3];
  logic [2:0]  en, timeout_err, cap_flags, timeout_hit, w1c_mask;
  logic [31:0] rdata, prdata_q, status;
  logic [2:0]  idx;
  logic        pend_hit, stall, done, acc_err, commit, rd_launch;
  logic        unused;

  assign idx    = paddr_i[4:2];
  assign unused = ^paddr_i[1:0];
  assign status = {23'b0, cap_flags, timeout_err, en};
  assign reg2ip_en_o   = en;
  assign reg2ip_data_o = {shadow[0], shadow[1], shadow[2]};

  always_comb begin
    pend_hit = 1'b0;
    rdata    = '0;
    case (idx)
      3'd0: begin pend_hit = en[0]; rdata = shadow[0]; end
      3'd1: begin pend_hit = en[1]; rdata = shadow[1]; end
      3'd2: begin pend_hit = en[2]; rdata = shadow[2]; end
      3'd3: rdata = snap[0];
      3'd4: rdata = snap[1];
      3'd5: rdata = snap[2];
      3'd6: rdata = status;
      default: rdata = '0;
    endcase
  end

  // 0x1C is a write-only W1C alias; reading it is an error, as is writing any RO slot
  assign acc_err   = pwrite_i ? (idx inside {3'd3, 3'd4, 3'd5, 3'd6}) : (idx == 3'd7);
  assign stall     = (state != IDLE) && pwrite_i && pend_hit;
  assign commit    = done && pwrite_i && !acc_err;
  assign rd_launch = (state == IDLE) && psel_i && !penable_i && !pwrite_i;
  assign w1c_mask  = (commit && idx == 3'd7) ? pwdata_i[5:3] : '0;

  always_comb begin
    for (int unsigned k = 0; k < 3; k++)
      timeout_hit[k] = en[k] && !reg2ip_ack_i[k] && (timer[k] == TIMER_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (psel_i && !penable_i) state_next = ACCESS;
      ACCESS, STALL: state_next = stall ? STALL : IDLE;
      default:       state_next = IDLE;
    endcase
  end

  always_comb begin
    done      = (state != IDLE) && !stall;
    pready_o  = done;
    pslverr_o = done && acc_err;
    prdata_o  = prdata_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prdata_q    <= '0;
      en          <= '0;
      timeout_err <= '0;
      cap_flags   <= '0;
      for (int unsigned k = 0; k < 3; k++) begin
        shadow[k] <= '0;
        snap[k]   <= '0;
        timer[k]  <= '0;
      end
    end else begin
      // read data is sampled at the setup edge so a same-cycle capture is not seen
      prdata_q    <= rd_launch ? rdata : '0;
      timeout_err <= (timeout_err & ~w1c_mask) | timeout_hit;
      for (int unsigned k = 0; k < 3; k++) begin
        if (commit && idx == 3'(k)) begin
          shadow[k] <= pwdata_i;
          en[k]     <= 1'b1;
          timer[k]  <= '0;
        end else if (en[k]) begin
          if (reg2ip_ack_i[k] || timeout_hit[k]) en[k] <= 1'b0;
          else timer[k] <= timer[k] + 8'd1;
        end
      end
      if (ip2reg_valid_i) begin
        if (ip2reg_data_i[66]) snap[0] <= ip2reg_data_i[98:67];
        if (ip2reg_data_i[33]) snap[1] <= ip2reg_data_i[65:34];
        if (ip2reg_data_i[0])  snap[2] <= ip2reg_data_i[32:1];
        cap_flags <= {ip2reg_data_i[66], ip2reg_data_i[33], ip2reg_data_i[0]};
      end
    end
  end
endmodule

// File: tb/tb_custom_ip_reg_bridge.sv
// Bench for custom_ip_reg_bridge: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_custom_ip_reg_bridge;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [95:0] r2i_data;
  logic [2:0]  r2i_en;
  logic [2:0]  ack = '0;
  logic [98:0] ip_data = '0;
  logic        ip_valid = 1'b0;

  always #5 clk = ~clk;

  custom_ip_reg_bridge #(.TIMEOUT(TO), .DATA_WIDTH(96)) dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .reg2ip_data_o(r2i_data), .reg2ip_en_o(r2i_en), .reg2ip_ack_i(ack),
    .ip2reg_data_i(ip_data), .ip2reg_valid_i(ip_valid)
  );

  int checks = 0, errors = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: strobe lifetime in cycles, register images, latched read value
  logic [31:0] m_sh [3];
  logic [31:0] m_snap [3];
  logic [31:0] m_rd;
  logic [2:0]  m_on, m_err, m_flags, m_i, m_set, m_clr;
  logic        m_fin;
  int          m_age [3];

  function automatic logic [31:0] m_read(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: return m_sh[i];
      3'd3: return m_snap[0];
      3'd4: return m_snap[1];
      3'd5: return m_snap[2];
      3'd6: return {23'b0, m_flags, m_err, m_on};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on = '0; m_err = '0; m_flags = '0; m_rd = '0;
      for (int k = 0; k < 3; k++) begin m_sh[k] = '0; m_snap[k] = '0; m_age[k] = 0; end
    end else begin
      m_i   = paddr[4:2];
      m_fin = psel && penable && !(pwrite && m_i < 3'd3 && m_on[m_i]);
      if (psel && !penable) m_rd = pwrite ? 32'h0 : m_read(m_i);
      m_set = '0;
      for (int k = 0; k < 3; k++) begin
        if (m_on[k]) begin
          if (ack[k]) m_on[k] = 1'b0;
          else if (m_age[k] == TO) begin m_on[k] = 1'b0; m_set[k] = 1'b1; end
          else m_age[k]++;
        end
      end
      m_clr = (m_fin && pwrite && m_i == 3'd7) ? pwdata[5:3] : 3'b0;
      m_err = (m_err & ~m_clr) | m_set;
      if (m_fin && pwrite && m_i < 3'd3) begin
        m_sh[m_i] = pwdata; m_on[m_i] = 1'b1; m_age[m_i] = 1;
      end
      if (ip_valid) begin
        if (ip_data[66]) m_snap[0] = ip_data[98:67];
        if (ip_data[33]) m_snap[1] = ip_data[65:34];
        if (ip_data[0])  m_snap[2] = ip_data[32:1];
        m_flags = {ip_data[66], ip_data[33], ip_data[0]};
      end
    end
  end

  logic [2:0]  c_i;
  logic        c_rdy, c_err;
  logic [31:0] c_rd;
  always @(negedge clk) begin
    if (!rst) begin
      c_i   = paddr[4:2];
      c_rdy = psel && penable && !(pwrite && c_i < 3'd3 && m_on[c_i]);
      c_err = c_rdy && (pwrite ? (c_i >= 3'd3 && c_i <= 3'd6) : (c_i == 3'd7));
      c_rd  = (c_rdy && !pwrite) ? m_rd : 32'h0;
      chk("pready", pready, c_rdy);
      chk("pslverr", pslverr, c_err);
      chk("prdata", prdata, c_rd);
      chk("reg2ip_en", r2i_en, m_on);
      chk("reg2ip_data", r2i_data, {m_sh[0], m_sh[1], m_sh[2]});
    end
  end

  // IP-side stimulus: ack either after a fixed strobe age or at random
  int ack_after [3] = '{0, 0, 0};
  int hi_cnt [3] = '{0, 0, 0};
  bit ack_rand = 1'b0, cap_rand = 1'b0;

  task automatic tick();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      hi_cnt[k] = r2i_en[k] ? hi_cnt[k] + 1 : 0;
      if (ack_rand) ack[k] = ($urandom_range(0, 4) == 0);
      else ack[k] = (ack_after[k] != 0 && hi_cnt[k] == ack_after[k]);
    end
    ip_valid = 1'b0;
    if (cap_rand) begin
      ip_valid = ($urandom_range(0, 2) == 0);
      ip_data  = {3'($urandom), $urandom, $urandom, $urandom};
    end
  endtask

  logic [31:0] t_rd;
  logic        t_er;
  int          t_w;

  task automatic apb(input logic [4:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int waits);
    bit got = 1'b0;
    rd = '0; er = 1'b0; waits = 0;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    tick();
    penable = 1'b1;
    while (!got && waits < 64) begin
      @(negedge clk);
      if (pready) begin got = 1'b1; rd = prdata; er = pslverr; end
      else waits++;
      tick();
    end
    chk("apb_complete", got, 1);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    apb(a, 1'b1, d, t_rd, t_er, t_w);
  endtask

  task automatic rd(input logic [4:0] a);
    apb(a, 1'b0, 32'h0, t_rd, t_er, t_w);
  endtask

  task automatic en_high_len(input int k, output int cnt);
    cnt = 0;
    while (r2i_en[k] && cnt < 64) begin cnt++; tick(); end
    chk("strobe_dropped", r2i_en[k], 0);
  endtask

  int n;

  initial begin
    repeat (2) tick();
    chk("rst_pready", pready, 0);
    chk("rst_en", r2i_en, 0);
    chk("rst_data", r2i_data, 0);
    chk("rst_prdata", prdata, 0);
    rst = 1'b0;
    tick();

    // ack on the third strobe cycle
    ack_after[1] = 3;
    wr(5'h04, 32'hDEADBEEF);
    chk("w04_err", t_er, 0);
    chk("w04_waits", t_w, 0);
    en_high_len(1, n);
    chk("en1_len", n, 3);
    chk("shadow1", r2i_data[63:32], 32'hDEADBEEF);
    rd(5'h18);
    chk("status_after_ack", t_rd, 32'h0);

    // back-to-back writes: the second waits for the first strobe
    ack_after[1] = 5;
    wr(5'h04, 32'h11112222);
    chk("b2b_first_waits", t_w, 0);
    wr(5'h04, 32'h33334444);
    chk("b2b_second_waits", t_w, 4);
    chk("b2b_second_err", t_er, 0);
    en_high_len(1, n);
    chk("b2b_en1_len", n, 5);
    chk("b2b_shadow1", r2i_data[63:32], 32'h33334444);

    // no ack: strobe lasts TIMEOUT cycles, sticky error, then W1C
    ack_after[0] = 0;
    wr(5'h00, 32'hCAFEF00D);
    en_high_len(0, n);
    chk("timeout_len", n, TO);
    rd(5'h18);
    chk("status_timeout", t_rd, 32'h08);
    wr(5'h1C, 32'h08);
    chk("w1c_err", t_er, 0);
    rd(5'h18);
    chk("status_cleared", t_rd, 32'h0);

    // ack on the very last strobe cycle beats the timeout
    ack_after[0] = TO;
    wr(5'h00, 32'h0BADC0DE);
    en_high_len(0, n);
    chk("ack_at_limit_len", n, TO);
    rd(5'h18);
    chk("status_ack_at_limit", t_rd, 32'h0);

    // capture with per-field valid flags; read racing a capture sees old data
    ip_valid = 1'b1;
    ip_data  = {32'h0, 1'b0, 32'h1111, 1'b1, 32'h0, 1'b0};
    tick();
    ip_valid = 1'b1;
    ip_data  = {32'h2468, 1'b1, 32'h369C, 1'b0, 32'h48D0, 1'b1};
    rd(5'h0C);
    chk("snap3_precapture", t_rd, 32'h0);
    rd(5'h0C);
    chk("snap3", t_rd, 32'h2468);
    rd(5'h10);
    chk("snap4_retained", t_rd, 32'h1111);
    rd(5'h14);
    chk("snap5", t_rd, 32'h48D0);
    rd(5'h18);
    chk("status_flags", t_rd, 32'h140);

    // error responses
    rd(5'h1C);
    chk("rd1c_err", t_er, 1);
    chk("rd1c_data", t_rd, 32'h0);
    wr(5'h0C, 32'hFFFFFFFF);
    chk("wr0c_err", t_er, 1);
    wr(5'h18, 32'hFFFFFFFF);
    chk("wr18_err", t_er, 1);
    rd(5'h0C);
    chk("snap3_unchanged", t_rd, 32'h2468);

    // reset during a live strobe and a stalled write
    ack_after = '{0, 0, 0};
    wr(5'h08, 32'hA5A5A5A5);
    psel = 1'b1; penable = 1'b0; paddr = 5'h08; pwrite = 1'b1; pwdata = 32'h12345678;
    tick();
    penable = 1'b1;
    tick(); tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", r2i_en, 0);
    chk("mid_rst_data", r2i_data, 0);
    chk("mid_rst_pready", pready, 0);
    chk("mid_rst_pslverr", pslverr, 0);
    chk("mid_rst_prdata", prdata, 0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    rd(5'h08);
    chk("post_rst_shadow2", t_rd, 32'h0);
    rd(5'h18);
    chk("post_rst_status", t_rd, 32'h0);

    // randomized traffic, checked each cycle by the model
    ack_rand = 1'b1;
    cap_rand = 1'b1;
    repeat (300) begin
      apb({3'($urandom_range(0, 7)), 2'($urandom)}, 1'($urandom), $urandom, t_rd, t_er, t_w);
      repeat ($urandom_range(0, 2)) tick();
    end
    ack_rand = 1'b0;
    cap_rand = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
